// File: rtl/vga_plot_capture.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_plot_capture : frame store behind the pixel-plot bus, with a registered
// debug read port and a start/done full-frame checksum scan.
// Optional macro VGA_CAPTURE_PATTERN_CHECK_EN adds mismatch_count (x mod 8).
// Revision: 1.0
// ----------------------------------------------------------------------------
module vga_plot_capture #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    input  logic [7:0]  rd_x,
    input  logic [6:0]  rd_y,
    output logic [2:0]  rd_colour,
    input  logic        scan_start,
    output logic        scan_done,
    output logic [17:0] checksum,
    output logic [15:0] plot_count,
    output logic        oob_err
`ifdef VGA_CAPTURE_PATTERN_CHECK_EN
    ,
    output logic [15:0] mismatch_count
`endif
);
    localparam int         DEPTH  = WIDTH * HEIGHT;
    localparam logic [8:0] X_LIM  = 9'(WIDTH);
    localparam logic [7:0] Y_LIM  = 8'(HEIGHT);
    localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
    localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [2:0]  frame [DEPTH];

    logic        plot_in_range, plot_wr, rd_in_range, scan_enter, scan_last;
    logic [14:0] plot_addr, rd_addr;

    logic [7:0]  scan_x;
    logic [6:0]  scan_y;
    logic [14:0] scan_addr;
    logic        issuing, data_valid, data_last, acc_last;
    logic [2:0]  scan_data;
    logic [17:0] acc;

    always_comb begin
        plot_in_range = ({1'b0, vga_x} < X_LIM) && ({1'b0, vga_y} < Y_LIM);
        plot_wr       = vga_plot && plot_in_range;
        plot_addr     = 15'(vga_x) * 15'(HEIGHT) + 15'(vga_y);
        rd_in_range   = ({1'b0, rd_x} < X_LIM) && ({1'b0, rd_y} < Y_LIM);
        rd_addr       = 15'(rd_x) * 15'(HEIGHT) + 15'(rd_y);
        scan_enter    = (state == IDLE) && scan_start;
        scan_last     = (scan_x == X_LAST) && (scan_y == Y_LAST);
    end

    // Store is never cleared; nonblocking update gives read-before-write.
    always_ff @(posedge clk) begin
        if (rst_n && plot_wr) begin
            frame[plot_addr] <= vga_colour;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_colour <= '0;
        end else if (rd_in_range) begin
            rd_colour <= frame[rd_addr];
        end else begin
            rd_colour <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            plot_count <= '0;
            oob_err    <= 1'b0;
        end else if (vga_plot) begin
            if (!plot_in_range) begin
                oob_err <= 1'b1;
            end else if (plot_count != 16'hFFFF) begin
                plot_count <= plot_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        scan_done  = 1'b0;
        case (state)
            IDLE: if (scan_start) state_next = SCAN;
            SCAN: if (acc_last) state_next = DONE;
            DONE: begin
                scan_done = 1'b1;
                if (!scan_start) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == SCAN && issuing) begin
            scan_data <= frame[scan_addr];
        end
    end

    // Pipeline: issue read -> data_valid/accumulate -> acc_last -> DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issuing    <= 1'b0;
            data_valid <= 1'b0;
            data_last  <= 1'b0;
            acc_last   <= 1'b0;
            acc        <= '0;
            checksum   <= '0;
            scan_x     <= '0;
            scan_y     <= '0;
            scan_addr  <= '0;
        end else if (scan_enter) begin
            issuing    <= 1'b1;
            data_valid <= 1'b0;
            data_last  <= 1'b0;
            acc_last   <= 1'b0;
            acc        <= '0;
            scan_x     <= '0;
            scan_y     <= '0;
            scan_addr  <= '0;
        end else if (state == SCAN) begin
            data_valid <= issuing;
            if (issuing) begin
                data_last <= scan_last;
                scan_addr <= scan_addr + 15'd1;
                if (scan_y == Y_LAST) begin
                    scan_y <= '0;
                    scan_x <= scan_x + 8'd1;
                end else begin
                    scan_y <= scan_y + 7'd1;
                end
                if (scan_last) issuing <= 1'b0;
            end
            if (data_valid) begin
                acc      <= acc + {15'd0, scan_data};
                acc_last <= data_last;
            end
            if (acc_last) checksum <= acc;
        end
    end

`ifdef VGA_CAPTURE_PATTERN_CHECK_EN
    logic [2:0] data_xmod;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mismatch_count <= '0;
            data_xmod      <= '0;
        end else if (scan_enter) begin
            mismatch_count <= '0;
        end else if (state == SCAN) begin
            if (issuing) data_xmod <= scan_x[2:0];
            if (data_valid && (scan_data != data_xmod) && (mismatch_count != 16'hFFFF)) begin
                mismatch_count <= mismatch_count + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_plot_capture.sv
`default_nettype none
// Testbench for vga_plot_capture: shadow frame model with queues of expected
// read-port data and scan results, checked as the DUT produces them.
module tb_vga_plot_capture;
    localparam int W   = 160;
    localparam int H   = 120;
    localparam int N   = W * H;
    localparam int LAT = N + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  vga_x, rd_x;
    logic [6:0]  vga_y, rd_y;
    logic [2:0]  vga_colour, rd_colour;
    logic        vga_plot, scan_start, scan_done, oob_err;
    logic [17:0] checksum;
    logic [15:0] plot_count;
`ifdef VGA_CAPTURE_PATTERN_CHECK_EN
    logic [15:0] mismatch_count;
`endif

    typedef struct {
        int csum;
        int mism;
    } scan_exp_t;

    int        rd_q[$];
    scan_exp_t sc_q[$];
    int        exp_mem [N];
    int        exp_count;
    bit        exp_oob;
    int        n_checks = 0;
    int        n_fail   = 0;

    always #5 clk = ~clk;

    vga_plot_capture #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_colour  (rd_colour),
        .scan_start (scan_start),
        .scan_done  (scan_done),
        .checksum   (checksum),
        .plot_count (plot_count),
        .oob_err    (oob_err)
`ifdef VGA_CAPTURE_PATTERN_CHECK_EN
        ,
        .mismatch_count (mismatch_count)
`endif
    );

    function automatic int model_read(input int x, input int y);
        if (x < W && y < H) return exp_mem[x*H + y];
        return 0;
    endfunction

    function automatic scan_exp_t model_scan();
        scan_exp_t r;
        r.csum = 0;
        r.mism = 0;
        for (int x = 0; x < W; x++) begin
            for (int y = 0; y < H; y++) begin
                r.csum += exp_mem[x*H + y];
                if (exp_mem[x*H + y] != x % 8) r.mism++;
            end
        end
        return r;
    endfunction

    task automatic plot(input int x, input int y, input int c);
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = 3'(c);
        vga_plot   = 1'b1;
        if (x < W && y < H) begin
            exp_mem[x*H + y] = c;
            if (exp_count < 65535) exp_count++;
        end else begin
            exp_oob = 1'b1;
        end
        @(posedge clk); #1;
        vga_plot = 1'b0;
    endtask

    // Call right after raising scan_start; edge 0 is the one that samples it.
    task automatic wait_done(input int drop_at, output int rose);
        rose = -1;
        for (int k = 0; k <= LAT + 50; k++) begin
            @(posedge clk); #1;
            if (k == drop_at) scan_start = 1'b0;
            if (scan_done) begin
                rose = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        vga_x      = 'x;
        vga_y      = 'x;
        vga_colour = 'x;
        vga_plot   = 1'bx;
        scan_start = 1'b0;
        rd_x       = '0;
        rd_y       = '0;
        exp_count  = 0;
        exp_oob    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (plot_count !== 16'd0) begin n_fail++; $display("FAIL reset_plot_count: got %0d expected 0", plot_count); end
        n_checks++; if (oob_err !== 1'b0) begin n_fail++; $display("FAIL reset_oob_err: got %b expected 0", oob_err); end
        n_checks++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL reset_scan_done: got %b expected 0", scan_done); end
        n_checks++; if (checksum !== 18'd0) begin n_fail++; $display("FAIL reset_checksum: got %0d expected 0", checksum); end
        n_checks++; if (rd_colour !== 3'd0) begin n_fail++; $display("FAIL reset_rd_colour: got %0d expected 0", rd_colour); end
`ifdef VGA_CAPTURE_PATTERN_CHECK_EN
        n_checks++; if (mismatch_count !== 16'd0) begin n_fail++; $display("FAIL reset_mismatch: got %0d expected 0", mismatch_count); end
`endif
        rst_n      = 1'b1;
        vga_plot   = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
    endtask

    task automatic test_fill_scan();
        int        rose;
        scan_exp_t e;
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                plot(x, y, x % 8);
        n_checks++; if (plot_count !== 16'(exp_count)) begin n_fail++; $display("FAIL fill_plot_count: got %0d expected %0d", plot_count, exp_count); end
        sc_q.push_back(model_scan());
        scan_start = 1'b1;
        wait_done(-1, rose);
        e = sc_q.pop_front();
        n_checks++; if (rose !== LAT) begin n_fail++; $display("FAIL fill_scan_latency: got %0d expected %0d", rose, LAT); end
        n_checks++; if (checksum !== 18'(e.csum)) begin n_fail++; $display("FAIL fill_checksum: got %0d expected %0d", checksum, e.csum); end
`ifdef VGA_CAPTURE_PATTERN_CHECK_EN
        n_checks++; if (mismatch_count !== 16'(e.mism)) begin n_fail++; $display("FAIL fill_mismatch: got %0d expected %0d", mismatch_count, e.mism); end
`endif
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++; if (scan_done !== 1'b1) begin n_fail++; $display("FAIL done_hold_%0d: got %b expected 1", i, scan_done); end
        end
        scan_start = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL done_drop: got %b expected 0", scan_done); end
        n_checks++; if (checksum !== 18'(e.csum)) begin n_fail++; $display("FAIL checksum_hold: got %0d expected %0d", checksum, e.csum); end
    endtask

    task automatic test_readback();
        int        rose;
        int        exp;
        scan_exp_t e;
        plot(10, 5, 7);
        rd_x = 8'd10;
        rd_y = 7'd5;
        rd_q.push_back(model_read(10, 5));
        @(posedge clk); #1;
        exp = rd_q.pop_front();
        n_checks++; if (rd_colour !== 3'(exp)) begin n_fail++; $display("FAIL read_10_5: got %0d expected %0d", rd_colour, exp); end

        // Rescan while dropping scan_start early in SCAN.
        sc_q.push_back(model_scan());
        scan_start = 1'b1;
        wait_done(10, rose);
        e = sc_q.pop_front();
        n_checks++; if (rose !== LAT) begin n_fail++; $display("FAIL rescan_latency: got %0d expected %0d", rose, LAT); end
        n_checks++; if (checksum !== 18'(e.csum)) begin n_fail++; $display("FAIL rescan_checksum: got %0d expected %0d", checksum, e.csum); end
`ifdef VGA_CAPTURE_PATTERN_CHECK_EN
        n_checks++; if (mismatch_count !== 16'(e.mism)) begin n_fail++; $display("FAIL rescan_mismatch: got %0d expected %0d", mismatch_count, e.mism); end
`endif
        @(posedge clk); #1;
        n_checks++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b expected 0", scan_done); end

        // Same-cycle write and read of one cell returns the old colour.
        vga_x      = 8'd20;
        vga_y      = 7'd3;
        vga_colour = 3'd6;
        vga_plot   = 1'b1;
        rd_x       = 8'd20;
        rd_y       = 7'd3;
        rd_q.push_back(model_read(20, 3));
        exp_mem[20*H + 3] = 6;
        exp_count++;
        @(posedge clk); #1;
        vga_plot = 1'b0;
        exp = rd_q.pop_front();
        n_checks++; if (rd_colour !== 3'(exp)) begin n_fail++; $display("FAIL rbw_old: got %0d expected %0d", rd_colour, exp); end
        rd_q.push_back(model_read(20, 3));
        @(posedge clk); #1;
        exp = rd_q.pop_front();
        n_checks++; if (rd_colour !== 3'(exp)) begin n_fail++; $display("FAIL rbw_new: got %0d expected %0d", rd_colour, exp); end

        plot(10, 5, 10 % 8);
        plot(20, 3, 20 % 8);
    endtask

    task automatic test_oob();
        int rx [5] = '{1, 0, 159, 200, 0};
        int ry [5] = '{0, 0, 119, 0, 120};
        int exp;
        plot(160, 0, 5);
        plot(0, 120, 5);
        n_checks++; if (oob_err !== exp_oob) begin n_fail++; $display("FAIL oob_err: got %b expected %b", oob_err, exp_oob); end
        n_checks++; if (plot_count !== 16'(exp_count)) begin n_fail++; $display("FAIL oob_plot_count: got %0d expected %0d", plot_count, exp_count); end
        for (int i = 0; i < 5; i++) begin
            rd_x = 8'(rx[i]);
            rd_y = 7'(ry[i]);
            rd_q.push_back(model_read(rx[i], ry[i]));
            @(posedge clk); #1;
            exp = rd_q.pop_front();
            n_checks++; if (rd_colour !== 3'(exp)) begin n_fail++; $display("FAIL oob_read_%0d_%0d: got %0d expected %0d", rx[i], ry[i], rd_colour, exp); end
        end
    endtask

    task automatic test_reset_mid_scan();
        int        rose;
        scan_exp_t e;
        scan_start = 1'b1;
        repeat (1001) @(posedge clk);
        #1;
        rst_n      = 1'b0;
        scan_start = 1'b0;
        exp_count  = 0;
        exp_oob    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++; if (checksum !== 18'd0) begin n_fail++; $display("FAIL midreset_checksum: got %0d expected 0", checksum); end
        n_checks++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL midreset_scan_done: got %b expected 0", scan_done); end
        n_checks++; if (plot_count !== 16'(exp_count)) begin n_fail++; $display("FAIL midreset_plot_count: got %0d expected %0d", plot_count, exp_count); end
        n_checks++; if (oob_err !== exp_oob) begin n_fail++; $display("FAIL midreset_oob_err: got %b expected %b", oob_err, exp_oob); end

        sc_q.push_back(model_scan());
        scan_start = 1'b1;
        wait_done(-1, rose);
        e = sc_q.pop_front();
        n_checks++; if (rose !== LAT) begin n_fail++; $display("FAIL fresh_scan_latency: got %0d expected %0d", rose, LAT); end
        n_checks++; if (checksum !== 18'(e.csum)) begin n_fail++; $display("FAIL fresh_checksum: got %0d expected %0d", checksum, e.csum); end
`ifdef VGA_CAPTURE_PATTERN_CHECK_EN
        n_checks++; if (mismatch_count !== 16'(e.mism)) begin n_fail++; $display("FAIL fresh_mismatch: got %0d expected %0d", mismatch_count, e.mism); end
`endif
        scan_start = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL fresh_done_drop: got %b expected 0", scan_done); end
    endtask

    initial begin
        test_reset();
        test_fill_scan();
        test_readback();
        test_oob();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
